// File: rtl/tile_map_arbiter.sv
// Tile RAM shared between the pixel renderer (active video) and buffered
// game-logic writes / board-clear sweep (blanking only).
module tile_map_arbiter #(
  parameter int         H_SQUARE   = 20,
  parameter int         V_SQUARE   = 20,
  parameter int         H_CELLS    = 32,
  parameter int         V_CELLS    = 24,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] ENT_EMPTY  = 2'd3
) (
  input  logic       iVGA_CLK,
  input  logic       iReset_n,
  input  logic [9:0] ivga_x,
  input  logic [9:0] ivga_y,
  input  logic       iVisible,
  output logic [1:0] oSprite,
  output logic       oSprite_vld,
  input  logic       iWr_req,
  input  logic [4:0] iWr_col,
  input  logic [4:0] iWr_row,
  input  logic [1:0] iWr_ent,
  output logic       oWr_ready,
  output logic       oWr_err,
  input  logic       iClear,
  output logic       oBusy
);

  localparam int NCELLS = H_CELLS * V_CELLS;
  localparam int ADDR_W = $clog2(NCELLS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic [1:0]        ram [NCELLS];
  logic [1:0]        ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [1:0]        ram_wdata;

  logic [9:0]        cell_x, cell_y;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oob, oob_d1, vis_d1;

  logic [ADDR_W+1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [ADDR_W+1:0] fifo_head;
  logic              fifo_full, fifo_empty, in_range, push, pop;
  logic [ADDR_W-1:0] push_addr;

  // Render address: cell index of the current pixel
  assign cell_x  = ivga_x / 10'(H_SQUARE);
  assign cell_y  = ivga_y / 10'(V_SQUARE);
  assign rd_addr = ADDR_W'(cell_y) * ADDR_W'(H_CELLS) + ADDR_W'(cell_x);
  assign rd_oob  = (ivga_x >= 10'(H_CELLS * H_SQUARE)) || (ivga_y >= 10'(V_CELLS * V_SQUARE));

  // Write-request FIFO; out-of-range requests are accepted but never stored
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign oWr_ready  = !fifo_full;
  assign in_range   = ({1'b0, iWr_col} < 6'(H_CELLS)) && ({1'b0, iWr_row} < 6'(V_CELLS));
  assign push       = iWr_req && oWr_ready && in_range;
  assign push_addr  = ADDR_W'(iWr_row) * ADDR_W'(H_CELLS) + ADDR_W'(iWr_col);
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge iVGA_CLK) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {push_addr, iWr_ent};
  end

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      oWr_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      oWr_err <= iWr_req && oWr_ready && !in_range;
    end
  end

  // Port arbitration: clear sweep beats FIFO drain; both only in blanking
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ram_we      = 1'b0;
    pop         = 1'b0;
    ram_wr_addr = fifo_head[ADDR_W+1:2];
    ram_wdata   = fifo_head[1:0];
    case (state_q)
      S_IDLE: begin
        if (!iVisible && !fifo_empty) begin
          ram_we = 1'b1;
          pop    = 1'b1;
        end
      end
      S_CLEAR: begin
        ram_wr_addr = clr_addr_q;
        ram_wdata   = ENT_EMPTY;
        if (!iVisible) begin
          ram_we = 1'b1;
          if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
          else                         clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
    endcase
    if (iClear) begin
      state_d    = S_CLEAR;
      clr_addr_d = '0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign oBusy = (state_q == S_CLEAR);

  // Single-port RAM: render read in active video, otherwise the arbitrated write
  always_ff @(posedge iVGA_CLK) begin
    if (iVisible)    ram_q <= ram[rd_addr];
    else if (ram_we) ram[ram_wr_addr] <= ram_wdata;
  end

  always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
    if (!iReset_n) begin
      oob_d1      <= 1'b0;
      vis_d1      <= 1'b0;
      oSprite     <= ENT_EMPTY;
      oSprite_vld <= 1'b0;
    end else begin
      oob_d1      <= rd_oob;
      vis_d1      <= iVisible;
      oSprite_vld <= vis_d1;
      if (vis_d1) oSprite <= oob_d1 ? ENT_EMPTY : ram_q;
    end
  end

endmodule
